// File: rtl/decode_pkg.sv
// decode_pkg: shared types and helpers for address_decoder_seq.
//   state_t    - FSM states (IDLE, DRIVE, HOLD)
//   CNT_WIDTH  - width of the pulse-width counter
//   onehot_of  - one-hot select vector for an address, zero when out of range
package decode_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int CNT_WIDTH = 8;

    // Returns a 256-bit one-hot vector with bit addr set, or all zeros when
    // addr is not below n. Callers slice off the lines they actually have.
    function automatic logic [255:0] onehot_of(input logic [7:0] addr,
                                               input int unsigned n);
        logic [255:0] v;
        v = '0;
        if (int'(addr) < int'(n))
            v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decode_pulse_timer.sv
// decode_pulse_timer: load/decrement counter that times a select pulse.
//   i_clk      - clock, rising edge
//   i_reset    - synchronous active-high reset, clears the counter
//   i_load     - load i_load_val (takes priority over decrement)
//   i_load_val - value to load (pulse width minus one)
//   i_dec      - decrement request; saturates at zero
//   o_zero     - counter is zero
module decode_pulse_timer
    import decode_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_zero
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/address_decoder_seq.sv
// address_decoder_seq: registered address decoder with valid/ready intake.
// Drives exactly one of NUM_OUTPUTS select lines, either as a timed pulse of
// PULSE_CYCLES cycles (PULSE_MODE=1) or held until i_ack (PULSE_MODE=0).
// Out-of-range addresses are rejected with a one-cycle o_error pulse.
// Optional feature macro: DECODE_PARITY_EN adds i_to_decode_parity (even
// parity over i_to_decode); a parity mismatch is rejected like a bad address.
//   i_clock            - clock, rising edge
//   i_reset            - synchronous active-high reset
//   i_enable           - global enable; dropping it aborts an active line
//   i_req_valid        - request present
//   o_req_ready        - request can be accepted (IDLE, enabled, not in reset)
//   i_to_decode        - address to decode
//   i_to_decode_parity - even-parity bit (DECODE_PARITY_EN only)
//   i_ack              - releases a held line in hold mode
//   o_decoded          - registered one-hot select lines
//   o_busy             - a line is currently driven
//   o_error            - one-cycle reject pulse
module address_decoder_seq
    import decode_pkg::*;
#(
    parameter int ADDR_WIDTH   = 2,
    parameter int NUM_OUTPUTS  = 2**ADDR_WIDTH,
    parameter int PULSE_MODE   = 1,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [ADDR_WIDTH-1:0]  i_to_decode,
`ifdef DECODE_PARITY_EN
    input  logic                   i_to_decode_parity,
`endif
    input  logic                   i_ack,
    output logic [NUM_OUTPUTS-1:0] o_decoded,
    output logic                   o_busy,
    output logic                   o_error
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_OUTPUTS-1:0] r_decoded;
    logic [NUM_OUTPUTS-1:0] w_decoded_nxt;
    logic                   r_error;
    logic                   w_error_nxt;

    logic                   w_accept;
    logic                   w_in_range;
    logic                   w_parity_ok;
    logic                   w_load;
    logic                   w_dec;
    logic                   w_cnt_zero;
    logic [255:0]           w_onehot_full;
    logic                   w_unused_onehot_hi;

    // ---------------------------------------------------------------
    // Request qualification
    // ---------------------------------------------------------------
    assign o_req_ready = (r_state == IDLE) && i_enable && !i_reset;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_in_range  = (int'(i_to_decode) < NUM_OUTPUTS);

`ifdef DECODE_PARITY_EN
    // Even parity: address bits plus parity bit must XOR to zero.
    assign w_parity_ok = ~^{i_to_decode, i_to_decode_parity};
`else
    assign w_parity_ok = 1'b1;
`endif

    assign w_onehot_full = onehot_of(8'(i_to_decode), NUM_OUTPUTS);
    // Lines above NUM_OUTPUTS are never set for an in-range address.
    assign w_unused_onehot_hi = |(w_onehot_full >> NUM_OUTPUTS);

    // ---------------------------------------------------------------
    // Pulse timer (only meaningful in pulse mode)
    // ---------------------------------------------------------------
    generate
        if (PULSE_MODE != 0) begin : g_timer
            decode_pulse_timer u_timer (
                .i_clk      (i_clock),
                .i_reset    (i_reset),
                .i_load     (w_load),
                .i_load_val (CNT_WIDTH'(PULSE_CYCLES - 1)),
                .i_dec      (w_dec),
                .o_zero     (w_cnt_zero)
            );
        end else begin : g_no_timer
            // DRIVE is unreachable in hold mode; timer controls go nowhere.
            logic w_unused_timer;
            assign w_unused_timer = w_load ^ w_dec;
            assign w_cnt_zero     = 1'b1;
        end
    endgenerate

    // ---------------------------------------------------------------
    // FSM: next state and output register inputs
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_decoded_nxt = r_decoded;
        w_error_nxt   = 1'b0;
        w_load        = 1'b0;
        w_dec         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_in_range && w_parity_ok) begin
                        w_decoded_nxt = w_onehot_full[NUM_OUTPUTS-1:0];
                        w_load        = 1'b1;
                        w_state_nxt   = (PULSE_MODE != 0) ? DRIVE : HOLD;
                    end else begin
                        w_error_nxt   = 1'b1;
                    end
                end
            end
            DRIVE: begin
                // Counter holds cycles remaining after the current one.
                if (!i_enable || w_cnt_zero) begin
                    w_decoded_nxt = '0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_dec         = 1'b1;
                end
            end
            HOLD: begin
                // Enable drop and Ack both release the line; no error either way.
                if (!i_enable || i_ack) begin
                    w_decoded_nxt = '0;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_decoded_nxt = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_decoded <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_decoded <= w_decoded_nxt;
            r_error   <= w_error_nxt;
        end
    end

    assign o_decoded = r_decoded;
    assign o_busy    = (r_state != IDLE);
    assign o_error   = r_error;

endmodule

// File: doc/address_decoder_seq.md
# address_decoder_seq

Parametrised, registered successor to the 1-bit address decoder. It accepts an ADDR_WIDTH-bit address through a valid/ready handshake and drives exactly one of NUM_OUTPUTS select lines. The line is driven either as a timed pulse or held until acknowledged. Out-of-range addresses are rejected with an error pulse. It sits between bus/request logic and the downstream enable fan-out.

## Interface
- ADDR_WIDTH, 2, address width; legal range 1..8.
- NUM_OUTPUTS, 2**ADDR_WIDTH, number of select lines; legal range 2..2**ADDR_WIDTH.
- PULSE_MODE, 1, 1 = timed pulse, 0 = hold until Ack.
- PULSE_CYCLES, 1, pulse width in cycles; legal range 1..255; ignored when PULSE_MODE=0.
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Enable  in  1  global enable.
- ReqValid  in  1  request present.
- ReqReady  out  1  request can be accepted.
- ToDecode  in  ADDR_WIDTH  address to decode.
- ToDecodeParity  in  1  even-parity bit over ToDecode; present only with DECODE_PARITY_EN.
- Ack  in  1  releases a held line (PULSE_MODE=0).
- Decoded  out  NUM_OUTPUTS  one-hot select lines; all lines registered.
- Busy  out  1  a line is currently driven.
- Error  out  1  one-cycle reject pulse.

## Operation
- States: IDLE, DRIVE, HOLD.
- ReqReady = (state==IDLE) && Enable && !Reset; it is combinational from registered state.
- Accept happens when ReqValid && ReqReady at a rising edge.
- Valid accept (ToDecode < NUM_OUTPUTS):
  - Decoded[ToDecode] is set.
  - PULSE_MODE=1: the FSM enters DRIVE and the counter loads PULSE_CYCLES-1.
  - PULSE_MODE=0: the FSM enters HOLD.
- Invalid accept (ToDecode >= NUM_OUTPUTS): Error=1 for one cycle, Decoded stays 0, and the FSM stays in IDLE.
- DRIVE:
  - While counter != 0, the counter decrements.
  - When counter == 0, Decoded clears and the FSM returns to IDLE.
- HOLD: on Ack=1, Decoded clears and the FSM returns to IDLE. Ack is ignored in IDLE and DRIVE.
- Enable=0 in DRIVE or HOLD aborts the cycle: Decoded clears at the next edge and the FSM returns to IDLE. No Error is raised.
- Busy = (state != IDLE).
- At most one Decoded bit is ever high.

## Timing
- Reset values: Decoded=0, Busy=0, Error=0, state IDLE, counter 0. ReqReady=0 while Reset is high.
- Reset during DRIVE or HOLD clears all outputs at that edge.
- Latency: accept at edge N gives Decoded valid from edge N through N+PULSE_CYCLES, i.e. high for exactly PULSE_CYCLES cycles.
- The cycle after the line drops is IDLE, so back-to-back accepts are spaced PULSE_CYCLES+1 cycles apart.
- Error asserts the cycle after the rejecting edge. ReqReady stays high, so the next request can be accepted on the following edge.
- Hold mode: Ack sampled at edge M clears Decoded after M, and ReqReady is high in the same cycle.
- Simultaneous Enable=0 and Ack in HOLD: the FSM returns to IDLE with no Error (same result either way).
- Simultaneous Reset and ReqValid: reset wins and nothing is accepted.

## Configuration
- DECODE_PARITY_EN defined:
  - The ToDecodeParity port exists.
  - A request whose XOR(ToDecode, ToDecodeParity) != 0 is rejected exactly like an out-of-range address: Error pulse, no line driven.
- Undefined: the port is absent and there is no parity check. Only the range check applies.

## Structure
- decode_pkg holds:
  - the state enum (IDLE, DRIVE, HOLD);
  - localparam CNT_WIDTH = 8;
  - the function onehot_of(addr, n).
- Sub-module decode_pulse_timer contains the load/decrement counter and its zero flag. It is instantiated only when PULSE_MODE=1.
- The top level holds the FSM, range/parity check and the output register.

## Test plan
- ADDR_WIDTH=2, PULSE_CYCLES=3; accept ToDecode=2 -> Decoded=4'b0100 for exactly 3 cycles, Busy matches, then ReqReady=1.
- NUM_OUTPUTS=3; request ToDecode=3 -> Error pulses 1 cycle, Decoded=0; a request with ToDecode=1 on the next edge is accepted -> 3'b010.
- PULSE_MODE=0; accept ToDecode=1, hold 10 cycles with Ack=0 -> Decoded=4'b0010 steady; Ack=1 -> cleared next cycle.
- Reset asserted mid-DRIVE, and separately Enable dropped mid-HOLD -> all outputs 0 at the next edge, no Error.
- With DECODE_PARITY_EN: ToDecode=2'b11 with parity 1 -> Error, no line driven; parity 0 -> Decoded=4'b1000.
- ReqValid held high continuously with random addresses -> each accept is followed by exactly one one-hot window, with gaps of at least 1 IDLE cycle.
